// File: rtl/io_map_pkg.sv
// Shared address map, status bit positions and UART transmit FSM encoding
// for the memory-mapped I/O page.
package io_map_pkg;

  localparam int unsigned IO_PAGE_BIT = 22;

  localparam logic [3:0] REG_LEDS        = 4'h0;
  localparam logic [3:0] REG_UART_DATA   = 4'h4;
  localparam logic [3:0] REG_UART_STATUS = 4'h8;
  localparam logic [3:0] REG_CYCLES      = 4'hC;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_FULL = 1;
  localparam int unsigned ST_OVF  = 2;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

endpackage

// File: rtl/io_responder_if.sv
// Processor memory bus as seen by the I/O responder; the processor is the master.
interface io_responder_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/uart_tx_shifter.sv
// 8N1 serial transmitter: baud counter, shift register and frame FSM. Takes a
// byte over a valid/ready handshake; ready is offered in idle and on the last stop-bit cycle.
module uart_tx_shifter import io_map_pkg::*; #(
  parameter int unsigned BIT_CYC = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       txd_o
);

  localparam int unsigned BaudW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BIT_CYC - 1);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             bit_end;

  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    ready_o = 1'b0;
    unique case (state_q)
      TxIdle: begin
        baud_d  = '0;
        ready_o = 1'b1;
        if (valid_i) begin
          shift_d = data_i;
          state_d = TxStart;
          txd_d   = 1'b0;
        end
      end
      TxStart: begin
        if (bit_end) begin
          state_d = TxData;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      TxData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = TxStop;
            txd_d   = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end
      end
      TxStop: begin
        if (bit_end) begin
          // Chain straight into the next start bit when a byte is waiting.
          ready_o = 1'b1;
          if (valid_i) begin
            shift_d = data_i;
            state_d = TxStart;
            txd_d   = 1'b0;
          end else begin
            state_d = TxIdle;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = TxIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= TxIdle;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign busy_o = (state_q != TxIdle);
  assign txd_o  = txd_q;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O page: LED register, buffered UART transmitter and cycle counter.
// The cycle counter exists only when IO_CYCLE_COUNTER_EN is defined; otherwise CYCLES reads 0.
module io_responder import io_map_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           resetn,
  io_responder_if.slave  bus,
  output logic [4:0]     LEDS,
  output logic           TXD
);

  localparam int unsigned BIT_CYC = CLK_FREQ_HZ / BAUD;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);

  logic        sel, rd_en, wr_en;
  logic [3:0]  offset;

  assign sel    = bus.mem_addr[IO_PAGE_BIT];
  assign offset = {bus.mem_addr[3:2], 2'b00};
  assign rd_en  = sel && bus.mem_rstrb;
  assign wr_en  = sel && (bus.mem_wmask != 4'b0000);

  // TX FIFO
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_empty, fifo_full;
  logic            push_req, push, pop;
  logic            tx_ready, tx_busy;
  logic [7:0]      fifo_head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_head  = fifo_q[rd_ptr_q];
  assign pop        = tx_ready && !fifo_empty;
  assign push_req   = wr_en && (offset == REG_UART_DATA) && bus.mem_wmask[0];
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  uart_tx_shifter #(
    .BIT_CYC (BIT_CYC)
  ) u_tx (
    .clk     (clk),
    .resetn  (resetn),
    .data_i  (fifo_head),
    .valid_i (!fifo_empty),
    .ready_o (tx_ready),
    .busy_o  (tx_busy),
    .txd_o   (TXD)
  );

  // Register file
  logic [4:0]  leds_q;
  logic        ovf_q;
  logic [31:0] rdata_q, rd_val, status, cycles;

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cycles_q;
  always_ff @(posedge clk) begin
    if (!resetn) cycles_q <= '0;
    else         cycles_q <= cycles_q + 32'd1;
  end
  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif

  always_comb begin
    status          = '0;
    status[ST_BUSY] = !fifo_empty || tx_busy;
    status[ST_FULL] = fifo_full;
    status[ST_OVF]  = ovf_q;
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      REG_LEDS:        rd_val = {27'b0, leds_q};
      REG_UART_STATUS: rd_val = status;
      REG_CYCLES:      rd_val = cycles;
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      leds_q  <= 5'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (rd_en) rdata_q <= rd_val;
      if (wr_en && (offset == REG_LEDS) && bus.mem_wmask[0]) leds_q <= bus.mem_wdata[4:0];
      if (push_req && !push) begin
        ovf_q <= 1'b1;
      end else if (wr_en && (offset == REG_UART_STATUS)) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign LEDS          = leds_q;

  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr[31:23], bus.mem_addr[21:4], bus.mem_addr[1:0],
                         bus.mem_wdata[31:8]};

endmodule

// File: tb/tb_io_responder.sv
// Randomised bench for io_responder against a frame-level reference model with a read scoreboard.
module tb_io_responder;

  localparam int unsigned CLK_FREQ_HZ = 1000;
  localparam int unsigned BAUD        = 100;
  localparam int unsigned DEPTH       = 4;
  localparam int          BIT         = 10;
  localparam int          FRAME       = 10 * BIT;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] leds;
  logic       txd;

  io_responder_if bus ();

  io_responder #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .LEDS   (leds),
    .TXD    (txd)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  m_fifo[$];
  logic [31:0] rd_q[$];
  int          m_left = 0;
  logic [7:0]  m_byte = 8'h00;
  logic [4:0]  m_leds = 5'h00;
  logic        m_ovf = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_cyc = '0;
  bit          m_started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int el;
    if (m_left == 0) return 1'b1;
    el = FRAME - m_left;
    if (el < BIT) return 1'b0;
    if (el < 9 * BIT) return m_byte[el / BIT - 1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_reg(input logic [1:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      2'd0: v = {27'b0, m_leds};
      2'd2: v = {29'b0, m_ovf, (m_fifo.size() == DEPTH),
                 (m_fifo.size() > 0) || (m_left > 0)};
      2'd3: begin
`ifdef IO_CYCLE_COUNTER_EN
        v = m_cyc;
`else
        v = '0;
`endif
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  initial begin : model
    logic       sel;
    logic [1:0] idx;
    bit         pop;
    forever begin
      @(posedge clk);
      m_started = 1'b1;
      if (!resetn) begin
        m_fifo.delete();
        m_left  = 0;
        m_leds  = 5'h00;
        m_ovf   = 1'b0;
        m_rdata = '0;
        m_cyc   = '0;
      end else begin
        sel = bus.mem_addr[22];
        idx = bus.mem_addr[3:2];
        pop = (m_fifo.size() > 0) && (m_left <= 1);
        if (bus.mem_rstrb && sel) m_rdata = model_reg(idx);
        if (bus.mem_rstrb) rd_q.push_back(m_rdata);
        if (m_left > 0) m_left--;
        if (pop) begin
          m_byte = m_fifo.pop_front();
          m_left = FRAME;
        end
        if (sel && bus.mem_wmask != 4'b0000) begin
          case (idx)
            2'd0: if (bus.mem_wmask[0]) m_leds = bus.mem_wdata[4:0];
            2'd1: if (bus.mem_wmask[0]) begin
              if (m_fifo.size() < DEPTH) m_fifo.push_back(bus.mem_wdata[7:0]);
              else m_ovf = 1'b1;
            end
            2'd2: m_ovf = 1'b0;
            default: ;
          endcase
        end
        m_cyc = m_cyc + 32'd1;
      end
    end
  end

  initial begin : monitor
    wait (m_started);
    forever begin
      @(negedge clk);
      while (rd_q.size() > 0) check("rdata", bus.mem_rdata, rd_q.pop_front());
      check("leds", {27'b0, leds}, {27'b0, m_leds});
      check("txd", {31'b0, txd}, {31'b0, exp_txd()});
    end
  end

  task automatic op(input logic [31:0] a, input logic r, input logic [31:0] d,
                    input logic [3:0] m);
    @(negedge clk);
    bus.mem_addr  = a;
    bus.mem_rstrb = r;
    bus.mem_wdata = d;
    bus.mem_wmask = m;
  endtask

  task automatic idle(input int n);
    repeat (n) op(32'h0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn        = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_rstrb = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin : stimulus
    logic [31:0] a;
    bus.mem_addr  = '0;
    bus.mem_rstrb = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset values and LED register masking
    op(32'h0040_0000, 1'b1, 32'h0, 4'h0);
    op(32'h0040_0008, 1'b1, 32'h0, 4'h0);
    op(32'h0040_0000, 1'b0, 32'h1F, 4'b0001);
    op(32'h0040_0000, 1'b1, 32'h00, 4'b0010);
    op(32'h0040_0000, 1'b1, 32'h0, 4'h0);

    // Single frame with periodic status polling
    op(32'h0040_0004, 1'b0, 32'h55, 4'b0001);
    for (int i = 0; i < FRAME + 10; i++) op(32'h0040_0008, (i % 7) == 0, 32'h0, 4'h0);

    // Burst of six pushes into a four-deep FIFO
    for (int i = 0; i < 6; i++) op(32'h0040_0004, 1'b0, 32'($urandom_range(0, 255)), 4'b0001);
    op(32'h0040_0008, 1'b1, 32'h0, 4'h0);
    for (int i = 0; i < 5 * FRAME + 10; i++) op(32'h0040_0008, (i % 13) == 0, 32'h0, 4'h0);
    op(32'h0040_0008, 1'b1, 32'h0, 4'hF);
    op(32'h0040_0008, 1'b1, 32'h0, 4'h0);

    // Accesses outside the I/O page
    op(32'h0000_0004, 1'b0, 32'hAB, 4'hF);
    op(32'h0000_0000, 1'b1, 32'h0, 4'h0);
    idle(5);

    // Cycle counter reads three cycles apart
    op(32'h0040_000C, 1'b1, 32'h0, 4'h0);
    idle(2);
    op(32'h0040_000C, 1'b1, 32'h0, 4'h0);

    // Reset in the middle of the data bits
    op(32'h0040_0004, 1'b0, 32'hA5, 4'b0001);
    op(32'h0040_0004, 1'b0, 32'h3C, 4'b0001);
    idle(40);
    pulse_reset();
    op(32'h0040_0008, 1'b1, 32'h0, 4'h0);
    op(32'h0040_0000, 1'b1, 32'h0, 4'h0);
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      a      = $urandom;
      a[22]  = ($urandom_range(0, 4) != 0);
      a[3:2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else if ($urandom_range(0, 2) == 0) begin
        idle(1);
      end else begin
        op(a, 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      end
    end
    idle(6 * FRAME);
    op(32'h0040_0008, 1'b1, 32'h0, 4'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
